// File: rtl/ql_bram_pl_master.sv
// PL daisy-chain initiator: turns a valid/ready command stream into PL write/read
// strobes and PL_INIT sequences, returning fixed-latency readback on a response channel.
module ql_bram_pl_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 36,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned INIT_CYCLES = 16
) (
    input  logic              PL_CLK_i,
    input  logic              reset,
    input  logic              init_req_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [1:0]        cmd_wen_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              PL_INIT_o,
    output logic              PL_ENA_o,
    output logic              PL_REN_o,
    output logic [1:0]        PL_WEN_o,
    output logic [ADDR_W-1:0] PL_ADDR_o,
    output logic [DATA_W-1:0] PL_DATA_o,
    input  logic [DATA_W-1:0] PL_DATA_i
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WRITE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_init_pend;
    logic                w_init_pend_nxt;
    logic                w_cmd_fire;
    logic                w_rsp_valid_nxt;
    logic [DATA_W-1:0]   w_rsp_data_nxt;
    logic                w_pl_init_nxt;
    logic                w_pl_ena_nxt;
    logic                w_pl_ren_nxt;
    logic [1:0]          w_pl_wen_nxt;
    logic [ADDR_W-1:0]   w_pl_addr_nxt;
    logic [DATA_W-1:0]   w_pl_data_nxt;

    assign cmd_ready_o = ~reset & (r_state == S_IDLE) & ~r_init_pend & ~init_req_i;
    assign w_cmd_fire  = cmd_valid_i & cmd_ready_o;

    // PL outputs are decoded from the next state so they are registered yet aligned with it
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_init_pend_nxt = r_init_pend | (init_req_i & (r_state != S_IDLE));
        w_rsp_valid_nxt = rsp_valid_o;
        w_rsp_data_nxt  = rsp_data_o;
        w_pl_init_nxt   = 1'b0;
        w_pl_ena_nxt    = 1'b0;
        w_pl_ren_nxt    = 1'b0;
        w_pl_wen_nxt    = 2'b00;
        w_pl_addr_nxt   = '0;
        w_pl_data_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                if (init_req_i || r_init_pend) begin
                    w_state_nxt     = S_INIT;
                    w_cnt_nxt       = CNT_W'(INIT_CYCLES);
                    w_init_pend_nxt = 1'b0;
                    w_pl_init_nxt   = 1'b1;
                    w_pl_ena_nxt    = 1'b1;
                end else if (w_cmd_fire) begin
                    if (!cmd_write_i) begin
                        w_state_nxt   = S_RD_ISSUE;
                        w_pl_ena_nxt  = 1'b1;
                        w_pl_ren_nxt  = 1'b1;
                        w_pl_addr_nxt = cmd_addr_i;
                    end else if (cmd_wen_i != 2'b00) begin
                        w_state_nxt   = S_WRITE;
                        w_pl_ena_nxt  = 1'b1;
                        w_pl_wen_nxt  = cmd_wen_i;
                        w_pl_addr_nxt = cmd_addr_i;
                        w_pl_data_nxt = cmd_data_i;
                    end
                end
            end
            S_INIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt     = r_cnt - CNT_W'(1);
                    w_pl_init_nxt = 1'b1;
                    w_pl_ena_nxt  = 1'b1;
                end
            end
            S_WRITE: begin
                w_state_nxt = S_IDLE;
            end
            S_RD_ISSUE: begin
                w_state_nxt = S_RD_WAIT;
                w_cnt_nxt   = CNT_W'(RD_LAT);
            end
            S_RD_WAIT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = PL_DATA_i;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PL_CLK_i or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_init_pend <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            busy_o      <= 1'b0;
            PL_INIT_o   <= 1'b0;
            PL_ENA_o    <= 1'b0;
            PL_REN_o    <= 1'b0;
            PL_WEN_o    <= 2'b00;
            PL_ADDR_o   <= '0;
            PL_DATA_o   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_init_pend <= w_init_pend_nxt;
            rsp_valid_o <= w_rsp_valid_nxt;
            rsp_data_o  <= w_rsp_data_nxt;
            busy_o      <= (w_state_nxt != S_IDLE);
            PL_INIT_o   <= w_pl_init_nxt;
            PL_ENA_o    <= w_pl_ena_nxt;
            PL_REN_o    <= w_pl_ren_nxt;
            PL_WEN_o    <= w_pl_wen_nxt;
            PL_ADDR_o   <= w_pl_addr_nxt;
            PL_DATA_o   <= w_pl_data_nxt;
        end
    end

endmodule

// File: tb/tb_ql_bram_pl_master.sv
// Directed bench for ql_bram_pl_master with a two-stage chain readback model.
module tb_ql_bram_pl_master;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 36;
    localparam int unsigned RD_LAT      = 2;
    localparam int unsigned INIT_CYCLES = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              init_req_i;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic              cmd_write_i;
    logic [1:0]        cmd_wen_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              busy_o;
    logic              PL_INIT_o;
    logic              PL_ENA_o;
    logic              PL_REN_o;
    logic [1:0]        PL_WEN_o;
    logic [ADDR_W-1:0] PL_ADDR_o;
    logic [DATA_W-1:0] PL_DATA_o;
    logic [DATA_W-1:0] PL_DATA_i;

    always #5 clk = ~clk;

    ql_bram_pl_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .INIT_CYCLES(INIT_CYCLES)
    ) dut (
        .PL_CLK_i(clk), .reset(reset), .init_req_i(init_req_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_wen_i(cmd_wen_i), .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o), .PL_INIT_o(PL_INIT_o), .PL_ENA_o(PL_ENA_o), .PL_REN_o(PL_REN_o),
        .PL_WEN_o(PL_WEN_o), .PL_ADDR_o(PL_ADDR_o), .PL_DATA_o(PL_DATA_o),
        .PL_DATA_i(PL_DATA_i)
    );

    // Chain model: data valid only in the second cycle after the read strobe
    logic [DATA_W-1:0] rd_value = '0;
    logic              cv0 = 1'b0, cv1 = 1'b0;
    logic [DATA_W-1:0] cq0 = '0, cq1 = '0;
    always @(posedge clk) begin
        cv0 <= PL_REN_o;
        cq0 <= rd_value;
        cv1 <= cv0;
        cq1 <= cq0;
    end
    assign PL_DATA_i = cv1 ? cq1 : 36'h0_DEAD_BEEF;

    logic [4:0] pl_ctl;
    assign pl_ctl = {PL_INIT_o, PL_ENA_o, PL_REN_o, PL_WEN_o};

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic issue_read(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] val);
        rd_value    = val;
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b0;
        cmd_wen_i   = 2'b11;
        cmd_addr_i  = addr;
        cmd_data_i  = 36'hF_FFFF_FFFF;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o, rsp_valid_o, busy_o} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_ctl: got %b want 00000000", {pl_ctl, cmd_ready_o, rsp_valid_o, busy_o});
        end
        vec_cnt++;
        if ({PL_ADDR_o, PL_DATA_o, rsp_data_o} !== '0) begin
            err_cnt++;
            $display("FAIL reset_bus: addr %h data %h rsp %h want 0", PL_ADDR_o, PL_DATA_o, rsp_data_o);
        end
        reset = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({cmd_ready_o, busy_o} !== 2'b10) begin
            err_cnt++;
            $display("FAIL reset_release: ready/busy %b want 10", {cmd_ready_o, busy_o});
        end
    endtask

    task automatic test_write();
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_wen_i   = 2'b11;
        cmd_addr_i  = 32'h0000_0040;
        cmd_data_i  = 36'h9_ABCD_1234;
        #1;
        vec_cnt++;
        if ({cmd_ready_o, pl_ctl} !== 6'b100000) begin
            err_cnt++;
            $display("FAIL wr_c0: ready/ctl %b want 100000", {cmd_ready_o, pl_ctl});
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o, busy_o} !== 7'b0101101) begin
            err_cnt++;
            $display("FAIL wr_strobe: ctl/ready/busy %b want 0101101", {pl_ctl, cmd_ready_o, busy_o});
        end
        vec_cnt++;
        if ({PL_ADDR_o, PL_DATA_o} !== {32'h0000_0040, 36'h9_ABCD_1234}) begin
            err_cnt++;
            $display("FAIL wr_bus: addr %h data %h want 00000040 9abcd1234", PL_ADDR_o, PL_DATA_o);
        end
        @(negedge clk);
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o, PL_ADDR_o, PL_DATA_o} !== {5'b0, 1'b1, 68'h0}) begin
            err_cnt++;
            $display("FAIL wr_after: ctl %b ready %b addr %h data %h", pl_ctl, cmd_ready_o, PL_ADDR_o, PL_DATA_o);
        end
    endtask

    task automatic test_read();
        rsp_ready_i = 1'b1;
        issue_read(32'h0000_0080, 36'h1_2345_6789);
        vec_cnt++;
        if (cmd_ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL rd_c0_ready: got %b want 1", cmd_ready_o);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        vec_cnt++;
        if ({pl_ctl, PL_ADDR_o, PL_DATA_o} !== {5'b01100, 32'h0000_0080, 36'h0}) begin
            err_cnt++;
            $display("FAIL rd_strobe: ctl %b addr %h data %h want 01100 80 0", pl_ctl, PL_ADDR_o, PL_DATA_o);
        end
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rsp_valid_o, pl_ctl, busy_o} !== 7'b0000001) begin
                err_cnt++;
                $display("FAIL rd_wait_c%0d: valid/ctl/busy %b want 0000001", c, {rsp_valid_o, pl_ctl, busy_o});
            end
        end
        @(negedge clk);
        vec_cnt++;
        if ({rsp_valid_o, rsp_data_o} !== {1'b1, 36'h1_2345_6789}) begin
            err_cnt++;
            $display("FAIL rd_rsp_c4: valid %b data %h want 1 123456789", rsp_valid_o, rsp_data_o);
        end
        @(negedge clk);
        vec_cnt++;
        if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
            err_cnt++;
            $display("FAIL rd_done: valid/ready %b want 01", {rsp_valid_o, cmd_ready_o});
        end
    endtask

    task automatic test_backpressure();
        rsp_ready_i = 1'b0;
        issue_read(32'h0000_0084, 36'h0_5555_AAAA);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            vec_cnt++;
            if ({rsp_valid_o, rsp_data_o, cmd_ready_o, pl_ctl} !== {1'b1, 36'h0_5555_AAAA, 1'b0, 5'b0}) begin
                err_cnt++;
                $display("FAIL bp_hold_%0d: valid %b data %h ready %b ctl %b", i, rsp_valid_o, rsp_data_o, cmd_ready_o, pl_ctl);
            end
            if (i < 9) @(negedge clk);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if ({rsp_valid_o, cmd_ready_o, busy_o} !== 3'b010) begin
            err_cnt++;
            $display("FAIL bp_release: valid/ready/busy %b want 010", {rsp_valid_o, cmd_ready_o, busy_o});
        end
    endtask

    task automatic test_init_priority();
        rsp_ready_i = 1'b1;
        init_req_i  = 1'b1;
        issue_read(32'h0000_00C0, 36'h0_0000_00C0);
        vec_cnt++;
        if (cmd_ready_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL init_blocks_cmd: ready %b want 0", cmd_ready_o);
        end
        @(negedge clk);
        init_req_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vec_cnt++;
            if ({pl_ctl, cmd_ready_o} !== 6'b110000) begin
                err_cnt++;
                $display("FAIL init_pulse_%0d: ctl/ready %b want 110000", i, {pl_ctl, cmd_ready_o});
            end
            @(negedge clk);
        end
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o} !== 6'b000001) begin
            err_cnt++;
            $display("FAIL init_end: ctl/ready %b want 000001", {pl_ctl, cmd_ready_o});
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        vec_cnt++;
        if ({pl_ctl, PL_ADDR_o} !== {5'b01100, 32'h0000_00C0}) begin
            err_cnt++;
            $display("FAIL init_then_read: ctl %b addr %h want 01100 c0", pl_ctl, PL_ADDR_o);
        end
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({rsp_valid_o, rsp_data_o} !== {1'b1, 36'h0_0000_00C0}) begin
            err_cnt++;
            $display("FAIL init_read_rsp: valid %b data %h want 1 c0", rsp_valid_o, rsp_data_o);
        end
        @(negedge clk);
        // second half: init requests arriving while a read is waiting
        issue_read(32'h0000_00C4, 36'h7_0000_00C4);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        init_req_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        init_req_i = 1'b0;
        vec_cnt++;
        if ({rsp_valid_o, rsp_data_o, PL_INIT_o} !== {1'b1, 36'h7_0000_00C4, 1'b0}) begin
            err_cnt++;
            $display("FAIL pend_rsp_first: valid %b data %h init %b", rsp_valid_o, rsp_data_o, PL_INIT_o);
        end
        @(negedge clk);
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o, rsp_valid_o} !== 7'b0) begin
            err_cnt++;
            $display("FAIL pend_idle: ctl/ready/valid %b want 0000000", {pl_ctl, cmd_ready_o, rsp_valid_o});
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            vec_cnt++;
            if (pl_ctl !== 5'b11000) begin
                err_cnt++;
                $display("FAIL pend_pulse_%0d: ctl %b want 11000", i, pl_ctl);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({pl_ctl, cmd_ready_o} !== 6'b000001) begin
                err_cnt++;
                $display("FAIL pend_once_%0d: ctl/ready %b want 000001", i, {pl_ctl, cmd_ready_o});
            end
        end
    endtask

    task automatic test_write_noop();
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_wen_i   = 2'b00;
        cmd_addr_i  = 32'h0000_0044;
        cmd_data_i  = 36'h0_0000_0001;
        #1;
        vec_cnt++;
        if (cmd_ready_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL noop_accept: ready %b want 1", cmd_ready_o);
        end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if ({pl_ctl, cmd_ready_o, busy_o} !== 7'b0000010) begin
                err_cnt++;
                $display("FAIL noop_quiet_%0d: ctl/ready/busy %b want 0000010", i, {pl_ctl, cmd_ready_o, busy_o});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid_i = 1'b1;
        cmd_write_i = 1'b1;
        cmd_wen_i   = 2'b01;
        cmd_addr_i  = 32'h0000_0050;
        cmd_data_i  = 36'h0_0000_0050;
        #1;
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if ({cmd_ready_o, PL_ENA_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                err_cnt++;
                $display("FAIL b2b_wr_%0d: ready/ena %b", i, {cmd_ready_o, PL_ENA_o});
            end
            @(negedge clk);
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        rsp_ready_i = 1'b1;
        issue_read(32'h0000_0088, 36'h3_3333_3333);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({pl_ctl, cmd_ready_o, rsp_valid_o, busy_o, PL_ADDR_o, PL_DATA_o, rsp_data_o} !== '0) begin
            err_cnt++;
            $display("FAIL mid_reset: ctl %b ready %b valid %b busy %b rsp %h", pl_ctl, cmd_ready_o, rsp_valid_o, busy_o, rsp_data_o);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rsp_valid_o, cmd_ready_o, busy_o, pl_ctl} !== 8'b01000000) begin
                err_cnt++;
                $display("FAIL post_reset_%0d: valid/ready/busy/ctl %b want 01000000", i, {rsp_valid_o, cmd_ready_o, busy_o, pl_ctl});
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        init_req_i  = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_wen_i   = 2'b00;
        cmd_addr_i  = '0;
        cmd_data_i  = '0;
        rsp_ready_i = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_init_priority();
        test_write_noop();
        test_back_to_back();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
